alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the single execute-stage `ALU` between two requesters: the integer issue path (port 0) and the load/store address-generation path (port 1). Each requester presents an `inst_type` opcode and two operands over a valid/ready handshake. A round-robin grant selects one request per cycle and drives it through a combinational `ALU` instance. The result is captured in a one-entry output register with its own valid/ready handshake, so downstream backpressure stalls both requesters cleanly.

## Interface
Parameters:
- `XLEN`, 32, operand and result width
- `TAG_W`, 3, width of the requester-supplied tag returned with the result
- `CNT_W`, 16, width of the contention counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous and active-high
- `req_valid_i[1:0]`  in  2  request valid, per port
- `req_ready_o[1:0]`  out  2  request accepted this cycle, per port
- `req_op_i[1:0]`  in  2×`inst_type`  opcode, per port
- `req_op1_i[1:0]`  in  2×`XLEN`  operand 1 (rs1/PC), per port
- `req_op2_i[1:0]`  in  2×`XLEN`  operand 2 (rs2/imm/shamt), per port
- `req_tag_i[1:0]`  in  2×`TAG_W`  opaque tag, per port
- `res_valid_o`  out  1  result register holds a result
- `res_ready_i`  in  1  consumer takes result this cycle
- `res_data_o`  out  `XLEN`  ALU result
- `res_src_o`  out  1  port that issued the result
- `res_tag_o`  out  `TAG_W`  tag of the issuing request
- `conflict_cnt_o`  out  `CNT_W`  saturating count of contended cycles

## Operation
- Output stage has two states:
  - EMPTY (`res_valid_o`=0): moves to FULL on accept.
  - FULL (`res_valid_o`=1): stays FULL on accept with `res_ready_i`=1, or when `res_ready_i`=0. Moves to EMPTY on `res_ready_i`=1 with no accept.
- `can_accept = !res_valid_o || res_ready_i`.
- Grant rules:
  - If exactly one `req_valid_i` is set, that port is granted.
  - If both are set, port `rr_ptr` is granted.
  - If none is set, there is no grant.
- `req_ready_o[p] = grant[p] && can_accept && !rst`. At most one bit is set per cycle.
- `req_ready_o` may depend combinationally on both `req_valid_i` bits. Requesters must not make valid depend on ready.
- On accept from port p:
  - `res_data_o <= ALU(req_op_i[p], req_op1_i[p], req_op2_i[p])`.
  - `res_src_o <= p`; `res_tag_o <= req_tag_i[p]`.
  - `rr_ptr <= ~p`.
- With no accept, `rr_ptr` holds.
- A requester holding valid with ready low must keep op, operands and tag stable.
- `conflict_cnt_o` increments by 1 on every cycle where both ports are valid and one port is not accepted. This includes cycles with no accept because `can_accept`=0. It saturates at all-ones.
- Operand and result widths are `XLEN` throughout. The arbiter does not modify operands; all opcode semantics belong to `ALU`.

## Timing
- Reset values:
  - `res_valid_o`=0, `res_data_o`=0, `res_src_o`=0, `res_tag_o`=0
  - `rr_ptr`=0 (port 0 wins the first contended cycle)
  - `conflict_cnt_o`=0
  - `req_ready_o`=0 while `rst`=1
- Latency: request accepted at the edge ending cycle N; result is visible with `res_valid_o`=1 during cycle N+1.
- Throughput: one result per cycle while `res_ready_i`=1.
- Simultaneous drain and accept in the same cycle: the register reloads and `res_valid_o` stays 1, with no bubble.
- Backpressure: while FULL with `res_ready_i`=0, both `req_ready_o` bits are 0, and the result and tag registers hold.
- Reset mid-operation: a buffered result is dropped. `res_valid_o`=0 the cycle after `rst` is sampled high. Requests presented during reset are not accepted and must be re-issued by the requesters.
- Counter at all-ones plus another contended cycle: the counter stays at all-ones with no wrap.

## Structure
- `riscv` package:
  - `inst_type` (existing).
  - New constant `ALU_PORTS = 2`.
  - New `typedef enum logic {SRC_ISSUE=0, SRC_AGU=1} alu_src_e`, used for `res_src_o`.
- Sub-module: a 2-way round-robin picker `rr_grant2`. Inputs are `valid[1:0]` and `ptr`; output is `grant[1:0]`; it is purely combinational.
- The existing `ALU` is instantiated once, fed by the granted port's mux.
- The output register, `rr_ptr` and the counter live in the top module.

## Test plan
- Port 0 only: ADD op1=5, op2=7, tag=3, `res_ready_i`=1 → next cycle `res_valid_o`=1, `res_data_o`=12, `res_src_o`=0, `res_tag_o`=3; `conflict_cnt_o`=0.
- Both ports valid for 4 cycles after reset. Port 0 issues SUB 10−3; port 1 issues XOR 0xF0^0x0F; `res_ready_i`=1 → grants alternate 0,1,0,1; results 7, 0xFF, 7, 0xFF; `conflict_cnt_o`=4.
- `res_ready_i`=0 for 3 cycles with port 1 valid (ADD 1+1) after one accepted result → `req_ready_o`=00 for those 3 cycles; first result holds. After `res_ready_i` rises, the drain and next accept occur in the same cycle, and the next cycle shows 2.
- Assert `rst` for one cycle while FULL and both ports valid → next cycle `res_valid_o`=0, `req_ready_o`=00 during reset, `rr_ptr`=0, `conflict_cnt_o`=0.
- With `CNT_W`=4, hold both ports valid for 20 cycles → `conflict_cnt_o` reaches 15 and stays 15.
- Random valid/ready on both ports over 10k cycles, checked by a scoreboard → every accepted request appears exactly once, in order, with the correct tag, src and `ALU` result. No port waits more than 2 accepts while continuously valid and `can_accept`.

Source files
------------

// File: rtl/riscv.sv
// rtl/riscv.sv - shared execute-stage types: ALU opcodes, arbiter source ids, output stage states
package riscv;

    // Execute-stage ALU opcode.
    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SLT  = 4'd3,
        SLTU = 4'd4,
        XOR  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        OR   = 4'd8,
        AND  = 4'd9
    } inst_type;

    // Number of requesters sharing the ALU.
    localparam int ALU_PORTS = 2;

    // Which requester issued a result.
    typedef enum logic {
        SRC_ISSUE = 1'b0,
        SRC_AGU   = 1'b1
    } alu_src_e;

    // One-entry result register occupancy.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/ALU.sv
// rtl/ALU.sv - combinational execute-stage ALU
//
// Ports:
//   op_i  opcode (inst_type)
//   a_i   operand 1 (rs1/PC)
//   b_i   operand 2 (rs2/imm/shamt)
//   y_o   result
module ALU
    import riscv::*;
#(
    parameter int XLEN = 32
) (
    input  inst_type          op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   y_o
);

    localparam int SH_W = $clog2(XLEN);

    // Shifts use only the low log2(XLEN) bits of operand 2.
    logic [SH_W-1:0] shamt;
    assign shamt = b_i[SH_W-1:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            ADD:  y_o = a_i + b_i;
            SUB:  y_o = a_i - b_i;
            SLL:  y_o = a_i << shamt;
            SLT:  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            SLTU: y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            XOR:  y_o = a_i ^ b_i;
            SRL:  y_o = a_i >> shamt;
            SRA:  y_o = $signed(a_i) >>> shamt;
            OR:   y_o = a_i | b_i;
            AND:  y_o = a_i & b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_grant2.sv
// rtl/rr_grant2.sv - combinational 2-way round-robin picker
//
// Ports:
//   valid_i  per-port request valid
//   ptr_i    port that wins when both are valid
//   grant_o  one-hot grant (zero when nothing is valid)
module rr_grant2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between issue and AGU requesters
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o  per-port request handshake
//   req_op_i, req_op1_i,
//   req_op2_i, req_tag_i     per-port opcode, operands and opaque tag
//   res_valid_o/res_ready_i  result handshake
//   res_data_o, res_src_o,
//   res_tag_o                ALU result, issuing port and its tag
//   conflict_cnt_o           saturating count of cycles with both ports valid
module alu_share_arbiter
    import riscv::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  inst_type             req_op_i  [1:0],
    input  logic [XLEN-1:0]      req_op1_i [1:0],
    input  logic [XLEN-1:0]      req_op2_i [1:0],
    input  logic [TAG_W-1:0]     req_tag_i [1:0],
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [XLEN-1:0]      res_data_o,
    output alu_src_e             res_src_o,
    output logic [TAG_W-1:0]     res_tag_o,
    output logic [CNT_W-1:0]     conflict_cnt_o
);

    out_state_e          state_q, state_d;
    logic                rr_ptr_q;
    logic [XLEN-1:0]     res_data_q;
    alu_src_e            res_src_q;
    logic [TAG_W-1:0]    res_tag_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [1:0]          grant;
    logic                can_accept;
    logic                accept;
    logic                sel;
    logic [XLEN-1:0]     alu_y;

    rr_grant2 u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    // The register can take a new result when empty or when its current
    // content leaves this same cycle.
    assign can_accept  = (state_q == OUT_EMPTY) || res_ready_i;
    assign req_ready_o = grant & {2{can_accept && !rst}};
    assign accept      = |req_ready_o;
    assign sel         = grant[1];

    ALU #(.XLEN(XLEN)) u_alu (
        .op_i (req_op_i[sel]),
        .a_i  (req_op1_i[sel]),
        .b_i  (req_op2_i[sel]),
        .y_o  (alu_y)
    );

    // Output stage occupancy: an accept always leaves it FULL; a drain
    // without a refill empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (accept) state_d = OUT_FULL;
            OUT_FULL:  if (res_ready_i && !accept) state_d = OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
    end

    // At most one port is accepted, so every cycle with both valid leaves
    // one port waiting, whether or not the other got through.
    always_comb begin
        cnt_d = cnt_q;
        if (req_valid_i == 2'b11 && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OUT_EMPTY;
            rr_ptr_q   <= 1'b0;
            res_data_q <= '0;
            res_src_q  <= SRC_ISSUE;
            res_tag_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                res_data_q <= alu_y;
                res_src_q  <= alu_src_e'(sel);
                res_tag_q  <= req_tag_i[sel];
                rr_ptr_q   <= ~sel;
            end
        end
    end

    assign res_valid_o    = (state_q == OUT_FULL);
    assign res_data_o     = res_data_q;
    assign res_src_o      = res_src_q;
    assign res_tag_o      = res_tag_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import riscv::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 3;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          req_valid_i;
    logic [1:0]          req_ready_o;
    inst_type            req_op_i  [1:0];
    logic [XLEN-1:0]     req_op1_i [1:0];
    logic [XLEN-1:0]     req_op2_i [1:0];
    logic [TAG_W-1:0]    req_tag_i [1:0];
    logic                res_valid_o;
    logic                res_ready_i;
    logic [XLEN-1:0]     res_data_o;
    alu_src_e            res_src_o;
    logic [TAG_W-1:0]    res_tag_o;
    logic [CNT_W-1:0]    conflict_cnt_o;

    logic [1:0]          r4_ready;
    logic                r4_valid;
    logic [XLEN-1:0]     r4_data;
    alu_src_e            r4_src;
    logic [TAG_W-1:0]    r4_tag;
    logic [3:0]          r4_cnt;

    alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_op1_i      (req_op1_i),
        .req_op2_i      (req_op2_i),
        .req_tag_i      (req_tag_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_data_o     (res_data_o),
        .res_src_o      (res_src_o),
        .res_tag_o      (res_tag_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(4)) dut4 (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (r4_ready),
        .req_op_i       (req_op_i),
        .req_op1_i      (req_op1_i),
        .req_op2_i      (req_op2_i),
        .req_tag_i      (req_tag_i),
        .res_valid_o    (r4_valid),
        .res_ready_i    (res_ready_i),
        .res_data_o     (r4_data),
        .res_src_o      (r4_src),
        .res_tag_o      (r4_tag),
        .conflict_cnt_o (r4_cnt)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: results waiting to be consumed, in acceptance order.
    typedef struct {
        logic [XLEN-1:0]  data;
        logic             src;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t       sb[$];
    logic       m_prio;     // port favoured on the next contended cycle
    int         m_cnt;      // contended cycles since reset (unsaturated)
    int         waits [2];  // other-port accepts while this port kept waiting
    logic [1:0] last_ready;

    function automatic logic [XLEN-1:0] ref_alu(input inst_type op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ADD:  return a + b;
            SUB:  return a - b;
            SLL:  return a << sh;
            SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU: return (a < b) ? 32'd1 : 32'd0;
            XOR:  return a ^ b;
            SRL:  return a >> sh;
            SRA:  return $signed(a) >>> sh;
            OR:   return a | b;
            AND:  return a & b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [1:0] exp_ready();
        logic can;
        if (rst) return 2'b00;
        can = (sb.size() == 0) || res_ready_i;
        if (!can) return 2'b00;
        case (req_valid_i)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return m_prio ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        logic [1:0] er;
        int         p;
        res_t       r;
        @(negedge clk);
        er = exp_ready();
        check_eq("req_ready", req_ready_o, er);
        check_eq("res_valid", res_valid_o, sb.size() != 0);
        if (sb.size() != 0) begin
            check_eq("res_data", res_data_o, sb[0].data);
            check_eq("res_src", res_src_o, sb[0].src);
            check_eq("res_tag", res_tag_o, sb[0].tag);
        end
        check_eq("cnt16", conflict_cnt_o, (m_cnt > 65535) ? 65535 : m_cnt);
        check_eq("cnt4", r4_cnt, (m_cnt > 15) ? 15 : m_cnt);
        check_eq("valid4", r4_valid, sb.size() != 0);
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_prio   = 1'b0;
            m_cnt    = 0;
            waits[0] = 0;
            waits[1] = 0;
        end else begin
            if (req_valid_i == 2'b11) m_cnt++;
            for (int q = 0; q < 2; q++) begin
                if (!req_valid_i[q] || er[q]) begin
                    waits[q] = 0;
                end else if (er != 2'b00) begin
                    waits[q]++;
                    check_eq("fairness", waits[q] <= 2, 1'b1);
                end
            end
            if (sb.size() != 0 && res_ready_i) void'(sb.pop_front());
            if (er != 2'b00) begin
                p = er[1] ? 1 : 0;
                r.data = ref_alu(req_op_i[p], req_op1_i[p], req_op2_i[p]);
                r.src  = er[1];
                r.tag  = req_tag_i[p];
                sb.push_back(r);
                m_prio = ~er[1];
            end
        end
        last_ready = er;
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input inst_type op,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [TAG_W-1:0] tag);
        req_valid_i[p] = v;
        req_op_i[p]    = op;
        req_op1_i[p]   = a;
        req_op2_i[p]   = b;
        req_tag_i[p]   = tag;
    endtask

    task automatic rand_req(input int p);
        set_req(p, $urandom_range(0, 3) != 0, inst_type'($urandom_range(0, 9)),
                $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
                TAG_W'($urandom));
    endtask

    initial begin
        m_prio = 1'b0; m_cnt = 0; waits[0] = 0; waits[1] = 0; last_ready = 2'b00;
        rst = 1'b1;
        res_ready_i = 1'b1;
        req_valid_i = 2'b00;
        set_req(0, 1'b0, ADD, '0, '0, '0);
        set_req(1, 1'b0, ADD, '0, '0, '0);
        repeat (2) cycle();
        rst = 1'b0;
        check_eq("rst_valid", res_valid_o, 1'b0);
        check_eq("rst_data", res_data_o, 0);
        check_eq("rst_src", res_src_o, 1'b0);
        check_eq("rst_tag", res_tag_o, 0);
        check_eq("rst_cnt", conflict_cnt_o, 0);

        // Single request from port 0.
        set_req(0, 1'b1, ADD, 32'd5, 32'd7, 3'd3);
        cycle();
        req_valid_i = 2'b00;
        check_eq("p0_valid", res_valid_o, 1'b1);
        check_eq("p0_data", res_data_o, 32'd12);
        check_eq("p0_src", res_src_o, 1'b0);
        check_eq("p0_tag", res_tag_o, 3'd3);
        check_eq("p0_cnt", conflict_cnt_o, 0);
        cycle();

        // Contention alternates starting from port 0.
        rst = 1'b1; cycle(); rst = 1'b0;
        set_req(0, 1'b1, SUB, 32'd10, 32'd3, 3'd1);
        set_req(1, 1'b1, XOR, 32'hF0, 32'h0F, 3'd2);
        for (int i = 0; i < 4; i++) begin
            #1 check_eq("alt_ready", req_ready_o, (i % 2) ? 2'b10 : 2'b01);
            cycle();
            check_eq("alt_data", res_data_o, (i % 2) ? 32'hFF : 32'd7);
            check_eq("alt_src", res_src_o, (i % 2) ? 1'b1 : 1'b0);
        end
        req_valid_i = 2'b00;
        check_eq("alt_cnt", conflict_cnt_o, 4);
        cycle();

        // Backpressure holds the first result and blocks both ports.
        rst = 1'b1; cycle(); rst = 1'b0;
        set_req(0, 1'b1, ADD, 32'd2, 32'd3, 3'd4);
        cycle();
        req_valid_i = 2'b00;
        res_ready_i = 1'b0;
        set_req(1, 1'b1, ADD, 32'd1, 32'd1, 3'd5);
        repeat (3) begin
            #1 check_eq("bp_ready", req_ready_o, 2'b00);
            cycle();
            check_eq("bp_hold", res_data_o, 32'd5);
        end
        res_ready_i = 1'b1;
        #1 check_eq("bp_release", req_ready_o, 2'b10);
        cycle();
        req_valid_i = 2'b00;
        check_eq("bp_valid", res_valid_o, 1'b1);
        check_eq("bp_data", res_data_o, 32'd2);
        check_eq("bp_tag", res_tag_o, 3'd5);
        cycle();

        // Reset while full with both ports valid.
        set_req(0, 1'b1, OR, 32'h0F00, 32'h00F0, 3'd6);
        set_req(1, 1'b1, AND, 32'hFFFF, 32'h0F0F, 3'd7);
        res_ready_i = 1'b0;
        cycle();
        check_eq("mr_full", res_valid_o, 1'b1);
        rst = 1'b1;
        #1 check_eq("mr_ready", req_ready_o, 2'b00);
        cycle();
        rst = 1'b0;
        check_eq("mr_valid", res_valid_o, 1'b0);
        check_eq("mr_cnt", conflict_cnt_o, 0);
        #1 check_eq("mr_ptr", req_ready_o, 2'b01);
        cycle();
        req_valid_i = 2'b00;
        res_ready_i = 1'b1;
        cycle();

        // Counter saturation on the narrow instance.
        rst = 1'b1; cycle(); rst = 1'b0;
        set_req(0, 1'b1, SLL, 32'd1, 32'd4, 3'd0);
        set_req(1, 1'b1, SRA, 32'h8000_0000, 32'd3, 3'd1);
        repeat (20) cycle();
        check_eq("sat_cnt4", r4_cnt, 4'd15);
        check_eq("sat_cnt16", conflict_cnt_o, 20);
        req_valid_i = 2'b00;
        cycle();

        // Random traffic; a waiting requester keeps its payload stable.
        for (int n = 0; n < 10000; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid_i[p] || last_ready[p]) rand_req(p);
            end
            res_ready_i = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 999) == 0;
            cycle();
        end
        rst = 1'b0;
        req_valid_i = 2'b00;
        res_ready_i = 1'b1;
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
